// File: rtl/coolgirl_flash_pkg.sv
// State encoding, JEDEC command bytes and the per-write decision logic
// for the CoolGirl PRG flash write sequencer.
package coolgirl_flash_pkg;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_UNL1    = 4'd1;
  localparam logic [3:0] ST_UNL2    = 4'd2;
  localparam logic [3:0] ST_PROG    = 4'd3;
  localparam logic [3:0] ST_ERS0    = 4'd4;
  localparam logic [3:0] ST_ERS1    = 4'd5;
  localparam logic [3:0] ST_ERS2    = 4'd6;
  localparam logic [3:0] ST_AUTOSEL = 4'd7;

  localparam logic [7:0] CMD_UNLOCK1 = 8'hAA;
  localparam logic [7:0] CMD_UNLOCK2 = 8'h55;
  localparam logic [7:0] CMD_PROG    = 8'hA0;
  localparam logic [7:0] CMD_ERASE   = 8'h80;
  localparam logic [7:0] CMD_AUTOSEL = 8'h90;
  localparam logic [7:0] CMD_RESET   = 8'hF0;
  localparam logic [7:0] CMD_SECTOR  = 8'h30;
  localparam logic [7:0] CMD_CHIP    = 8'h10;

  typedef enum logic [3:0] {
    S_IDLE    = ST_IDLE,
    S_UNL1    = ST_UNL1,
    S_UNL2    = ST_UNL2,
    S_PROG    = ST_PROG,
    S_ERS0    = ST_ERS0,
    S_ERS1    = ST_ERS1,
    S_ERS2    = ST_ERS2,
    S_AUTOSEL = ST_AUTOSEL
  } seq_state_t;

  typedef struct packed {
    logic       allow;
    logic       prog;
    logic       erase;
    seq_state_t next;
  } seq_step_t;

  // Decides what a qualified write does from the given state.
  function automatic seq_step_t seq_decode(input seq_state_t st, input logic [7:0] data,
                                           input logic a1, input logic a2);
    seq_step_t step;
    step.allow = 1'b0;
    step.prog  = 1'b0;
    step.erase = 1'b0;
    step.next  = S_IDLE;
    if (st == S_PROG) begin
      // The program data slot takes any byte, including $F0, as data.
      step.allow = 1'b1;
      step.prog  = 1'b1;
    end else if (data == CMD_RESET) begin
      step.allow = 1'b1;
    end else begin
      case (st)
        S_IDLE: if (data == CMD_UNLOCK1 && a1) begin
          step.allow = 1'b1;
          step.next  = S_UNL1;
        end
        S_UNL1: if (data == CMD_UNLOCK2 && a2) begin
          step.allow = 1'b1;
          step.next  = S_UNL2;
        end
        S_UNL2: if (a1) begin
          if (data == CMD_PROG) begin
            step.allow = 1'b1;
            step.next  = S_PROG;
          end else if (data == CMD_ERASE) begin
            step.allow = 1'b1;
            step.next  = S_ERS0;
          end else if (data == CMD_AUTOSEL) begin
            step.allow = 1'b1;
            step.next  = S_AUTOSEL;
          end
        end
        S_ERS0: if (data == CMD_UNLOCK1 && a1) begin
          step.allow = 1'b1;
          step.next  = S_ERS1;
        end
        S_ERS1: if (data == CMD_UNLOCK2 && a2) begin
          step.allow = 1'b1;
          step.next  = S_ERS2;
        end
        S_ERS2: if (data == CMD_SECTOR || (data == CMD_CHIP && a1)) begin
          step.allow = 1'b1;
          step.erase = 1'b1;
        end
        default: ;
      endcase
      // A stray first-unlock write restarts the sequence instead of being lost.
      if (!step.allow && data == CMD_UNLOCK1 && a1) begin
        step.allow = 1'b1;
        step.next  = S_UNL1;
      end
    end
    return step;
  endfunction

  function automatic logic seq_timed(input seq_state_t st);
    return st inside {S_UNL1, S_UNL2, S_PROG, S_ERS0, S_ERS1, S_ERS2};
  endfunction

endpackage

// File: rtl/flash_seq_timer.sv
// Saturating idle counter on the falling clock edge; expired flags the edge
// on which the count would reach LIMIT.
module flash_seq_timer #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] LAST_W  = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_reg;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (run && count_reg != LIMIT_W) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = run & (count_reg >= LAST_W);

endmodule

// File: rtl/coolgirl_flash_write_sequencer.sv
// Tracks the JEDEC command protocol on the CPU bus and permits a flash write
// only when it is a legal next step of an unlock/program/erase/autoselect sequence.
module coolgirl_flash_write_sequencer
  import coolgirl_flash_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [11:0] UNLOCK_ADDR1   = 12'hAAA,
  parameter logic [11:0] UNLOCK_ADDR2   = 12'h555
) (
  input  logic        m2,
  input  logic        reset_n,
  input  logic        prg_write_enabled,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  output logic        flash_we_allow,
  output logic [3:0]  seq_state,
  output logic        prog_pulse,
  output logic        erase_pulse,
  output logic [15:0] prog_count
);

  seq_state_t state_reg;
  seq_step_t  step;
  logic       bus_wr;
  logic       a1;
  logic       a2;
  logic       accept;
  logic       expired;
  logic       timer_run;
  logic       timer_clear;
  logic       unused_addr_hi;

  // m2 is left out here so the same qualifier is valid when sampled on the falling edge.
  assign bus_wr = ~romsel & ~cpu_rw_in & prg_write_enabled;
  assign a1     = (cpu_addr_in[11:0] == UNLOCK_ADDR1);
  assign a2     = (cpu_addr_in[11:0] == UNLOCK_ADDR2);
  assign step   = seq_decode(state_reg, cpu_data_in, a1, a2);
  assign accept = bus_wr & step.allow;

  assign flash_we_allow = reset_n & m2 & accept;
  assign seq_state      = state_reg;
  assign unused_addr_hi = ^cpu_addr_in[14:12];

  assign timer_run   = seq_timed(state_reg);
  assign timer_clear = accept | ~timer_run;

  flash_seq_timer #(
    .LIMIT (TIMEOUT_CYCLES),
    .WIDTH (16)
  ) u_timer (
    .clk     (m2),
    .rst_n   (reset_n),
    .clear   (timer_clear),
    .run     (timer_run),
    .expired (expired)
  );

  always_ff @(negedge m2 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      prog_pulse  <= 1'b0;
      erase_pulse <= 1'b0;
      prog_count  <= '0;
    end else begin
      prog_pulse  <= 1'b0;
      erase_pulse <= 1'b0;
      if (!prg_write_enabled) begin
        state_reg <= S_IDLE;
      end else if (bus_wr) begin
        // A write on the timeout edge takes precedence over the timeout.
        state_reg   <= step.next;
        prog_pulse  <= step.prog;
        erase_pulse <= step.erase;
        if (step.prog) begin
          prog_count <= prog_count + 16'd1;
        end
      end else if (expired) begin
        state_reg <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_coolgirl_flash_write_sequencer.sv
// Scoreboard bench: a command-sequence table model predicts every bus cycle,
// and a separate monitor compares the DUT against the queued predictions.
module tb_coolgirl_flash_write_sequencer;

  localparam int TIMEOUT = 255;
  localparam logic [14:0] AD1 = 15'h0AAA;
  localparam logic [14:0] AD2 = 15'h0555;

  logic        m2;
  logic        reset_n;
  logic        prg_write_enabled;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        flash_we_allow;
  logic [3:0]  seq_state;
  logic        prog_pulse;
  logic        erase_pulse;
  logic [15:0] prog_count;

  coolgirl_flash_write_sequencer dut (
    .m2                (m2),
    .reset_n           (reset_n),
    .prg_write_enabled (prg_write_enabled),
    .romsel            (romsel),
    .cpu_rw_in         (cpu_rw_in),
    .cpu_addr_in       (cpu_addr_in),
    .cpu_data_in       (cpu_data_in),
    .flash_we_allow    (flash_we_allow),
    .seq_state         (seq_state),
    .prog_pulse        (prog_pulse),
    .erase_pulse       (erase_pulse),
    .prog_count        (prog_count)
  );

  initial begin
    m2 = 1'b0;
    forever #10 m2 = ~m2;
  end

  typedef struct {
    bit          is_wr;
    logic [14:0] a;
    logic [7:0]  d;
    bit          allow;
    logic [3:0]  st;
    bit          pp;
    bit          ep;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: accepted command bytes since the last return to idle,
  // matched against the table of legal command sequences.
  logic [7:0]  prefix[$];
  int          idle_edges;
  logic [15:0] m_cnt;
  logic [7:0]  seq_d[4][6];
  int          seq_c[4][6];  // 0 any addr, 1 unlock addr 1, 2 unlock addr 2, 3 any addr and data
  int          seq_len[4];

  task automatic init_tables();
    seq_d[0] = '{8'hAA, 8'h55, 8'hA0, 8'h00, 8'h00, 8'h00}; seq_c[0] = '{1, 2, 1, 3, 0, 0}; seq_len[0] = 4;
    seq_d[1] = '{8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h30}; seq_c[1] = '{1, 2, 1, 1, 2, 0}; seq_len[1] = 6;
    seq_d[2] = '{8'hAA, 8'h55, 8'h80, 8'hAA, 8'h55, 8'h10}; seq_c[2] = '{1, 2, 1, 1, 2, 1}; seq_len[2] = 6;
    seq_d[3] = '{8'hAA, 8'h55, 8'h90, 8'hF0, 8'h00, 8'h00}; seq_c[3] = '{1, 2, 1, 0, 0, 0}; seq_len[3] = 4;
  endtask

  function automatic void chk(string name, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic bit step_ok(int s, int i, logic [7:0] d, bit a1, bit a2);
    case (seq_c[s][i])
      3: return 1'b1;
      1: return (d == seq_d[s][i]) && a1;
      2: return (d == seq_d[s][i]) && a2;
      default: return d == seq_d[s][i];
    endcase
  endfunction

  function automatic int find_seq(logic [7:0] d, bit a1, bit a2);
    bit ok;
    for (int s = 0; s < 4; s++) begin
      ok = prefix.size() < seq_len[s];
      for (int k = 0; k < prefix.size() && ok; k++)
        if (prefix[k] != seq_d[s][k]) ok = 1'b0;
      if (ok && step_ok(s, prefix.size(), d, a1, a2)) return s;
    end
    return -1;
  endfunction

  function automatic bit timed();
    return prefix.size() > 0 && !(prefix.size() == 3 && prefix[2] == 8'h90);
  endfunction

  function automatic logic [3:0] model_state();
    case (prefix.size())
      0: return 4'd0;
      1: return 4'd1;
      2: return 4'd2;
      3: return (prefix[2] == 8'hA0) ? 4'd3 : (prefix[2] == 8'h80) ? 4'd4 : 4'd7;
      4: return 4'd5;
      default: return 4'd6;
    endcase
  endfunction

  function automatic void model_step(bit w, bit pwe, logic [14:0] a, logic [7:0] d, output exp_t e);
    bit a1;
    bit a2;
    int s;
    a1 = (a[11:0] == 12'hAAA);
    a2 = (a[11:0] == 12'h555);
    e.allow = 1'b0;
    e.pp    = 1'b0;
    e.ep    = 1'b0;
    if (!pwe) begin
      prefix.delete();
      idle_edges = 0;
    end else if (w) begin
      s = find_seq(d, a1, a2);
      idle_edges = 0;
      if (s >= 0) begin
        e.allow = 1'b1;
        prefix.push_back(d);
        if (prefix.size() == seq_len[s]) begin
          if (s == 0) begin
            e.pp  = 1'b1;
            m_cnt = m_cnt + 16'd1;
          end
          if (s == 1 || s == 2) e.ep = 1'b1;
          prefix.delete();
        end
      end else if (d == 8'hF0) begin
        e.allow = 1'b1;
        prefix.delete();
      end else if (d == 8'hAA && a1) begin
        e.allow = 1'b1;
        prefix.delete();
        prefix.push_back(d);
      end else begin
        prefix.delete();
      end
    end else if (timed()) begin
      idle_edges++;
      if (idle_edges == TIMEOUT) begin
        prefix.delete();
        idle_edges = 0;
      end
    end
    e.st  = model_state();
    e.cnt = m_cnt;
  endfunction

  // One bus cycle, entered shortly after a falling edge and left just after the next one.
  task automatic cyc(bit is_wr, bit sel, logic [14:0] a, logic [7:0] d, bit pwe);
    exp_t e;
    romsel            = ~sel;
    cpu_rw_in         = ~is_wr;
    cpu_addr_in       = a;
    cpu_data_in       = d;
    prg_write_enabled = pwe;
    model_step(is_wr && sel, pwe, a, d, e);
    e.is_wr = is_wr && sel;
    e.a     = a;
    e.d     = d;
    exp_q.push_back(e);
    @(negedge m2);
    #2;
  endtask

  task automatic wr(logic [14:0] a, logic [7:0] d);
    cyc(1'b1, 1'b1, a, d, 1'b1);
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'b0, 15'h0000, 8'h00, 1'b1);
  endtask

  task automatic do_reset();
    romsel    = 1'b1;
    cpu_rw_in = 1'b1;
    reset_n   = 1'b0;
    prefix.delete();
    idle_edges = 0;
    m_cnt      = 16'd0;
    #1;
    chk("mid_reset_state", 16'(seq_state), 16'd0);
    chk("mid_reset_count", prog_count, 16'd0);
    chk("mid_reset_prog_pulse", 16'(prog_pulse), 16'd0);
    chk("mid_reset_erase_pulse", 16'(erase_pulse), 16'd0);
    @(negedge m2);
    #2;
    reset_n = 1'b1;
  endtask

  function automatic logic [14:0] rand_addr(int cls);
    logic [14:0] r;
    r = 15'($urandom);
    if (cls == 1) r[11:0] = 12'hAAA;
    else if (cls == 2) r[11:0] = 12'h555;
    return r;
  endfunction

  function automatic logic [7:0] pick_cmd();
    case ($urandom_range(0, 8))
      0: return 8'hAA;
      1: return 8'h55;
      2: return 8'hA0;
      3: return 8'h80;
      4: return 8'h90;
      5: return 8'hF0;
      6: return 8'h30;
      7: return 8'h10;
      default: return 8'($urandom);
    endcase
  endfunction

  // Monitor: pops one prediction per bus cycle and compares it with the DUT.
  initial begin
    exp_t cur;
    forever begin
      @(posedge m2);
      #5;
      if (exp_q.size() > 0) begin
        cur = exp_q.pop_front();
        chk("we_allow", 16'(flash_we_allow), 16'(cur.allow));
        @(negedge m2);
        #1;
        chk("seq_state", 16'(seq_state), 16'(cur.st));
        chk("prog_pulse", 16'(prog_pulse), 16'(cur.pp));
        chk("erase_pulse", 16'(erase_pulse), 16'(cur.ep));
        chk("prog_count", prog_count, cur.cnt);
        if (cur.is_wr)
          $display("txn wr addr=%h data=%h allow=%0d state=%0d count=%0d",
                   cur.a, cur.d, flash_we_allow, seq_state, prog_count);
      end
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish in time, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    init_tables();
    prefix.delete();
    idle_edges = 0;
    m_cnt      = 16'd0;

    // A write presented during reset must not reach the flash.
    reset_n           = 1'b0;
    prg_write_enabled = 1'b1;
    romsel            = 1'b0;
    cpu_rw_in         = 1'b0;
    cpu_addr_in       = AD1;
    cpu_data_in       = 8'hAA;
    @(posedge m2);
    #5;
    chk("reset_we_allow", 16'(flash_we_allow), 16'd0);
    chk("reset_state", 16'(seq_state), 16'd0);
    chk("reset_count", prog_count, 16'd0);
    chk("reset_prog_pulse", 16'(prog_pulse), 16'd0);
    chk("reset_erase_pulse", 16'(erase_pulse), 16'd0);
    @(negedge m2);
    #2;
    romsel    = 1'b1;
    cpu_rw_in = 1'b1;
    reset_n   = 1'b1;
    idle(2);

    // Program one byte.
    wr(AD1, 8'hAA); wr(AD2, 8'h55); wr(AD1, 8'hA0); wr(15'h1234, 8'h3C);
    idle(2);
    // Mapper bank write from idle.
    wr(15'h0000, 8'h05);
    idle(1);
    // Sector erase, then chip erase.
    wr(AD1, 8'hAA); wr(AD2, 8'h55); wr(AD1, 8'h80); wr(AD1, 8'hAA); wr(AD2, 8'h55); wr(15'h4000, 8'h30);
    idle(1);
    wr(AD1, 8'hAA); wr(AD2, 8'h55); wr(AD1, 8'h80); wr(AD1, 8'hAA); wr(AD2, 8'h55); wr(AD1, 8'h10);
    idle(1);
    // Timeout, then an orphaned second unlock.
    wr(AD1, 8'hAA); idle(TIMEOUT); wr(AD2, 8'h55);
    // A write on the timeout edge wins.
    wr(AD1, 8'hAA); idle(TIMEOUT - 1); wr(AD2, 8'h55); wr(15'h0000, 8'hF0);
    // Autoselect holds without timing out.
    wr(AD1, 8'hAA); wr(AD2, 8'h55); wr(AD1, 8'h90); idle(1000); wr(15'h0000, 8'hF0);
    idle(1);
    // Config bit dropped mid-sequence.
    wr(AD1, 8'hAA); wr(AD2, 8'h55); cyc(1'b1, 1'b1, AD1, 8'hA0, 1'b0); wr(15'h0100, 8'h77);
    // Reset mid-sequence, and reset cancelling a live program pulse.
    wr(AD1, 8'hAA); wr(AD2, 8'h55); do_reset();
    wr(AD1, 8'hAA); wr(AD2, 8'h55); wr(AD1, 8'hA0); wr(15'h2000, 8'h11); do_reset();
    idle(1);

    for (int t = 0; t < 250; t++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0, 1: begin
          wr(rand_addr(1), 8'hAA); wr(rand_addr(2), 8'h55); wr(rand_addr(1), 8'hA0);
          wr(rand_addr(0), 8'($urandom));
        end
        2: begin
          wr(rand_addr(1), 8'hAA); wr(rand_addr(2), 8'h55); wr(rand_addr(1), 8'h80);
          wr(rand_addr(1), 8'hAA); wr(rand_addr(2), 8'h55);
          if ($urandom_range(0, 1) == 0) wr(rand_addr(0), 8'h30);
          else wr(rand_addr($urandom_range(0, 1)), 8'h10);
        end
        3: begin
          wr(rand_addr(1), 8'hAA); wr(rand_addr(2), 8'h55); wr(rand_addr(1), 8'h90);
          idle($urandom_range(0, 3));
          wr(rand_addr(0), 8'hF0);
        end
        4, 5: wr(rand_addr($urandom_range(0, 2)), pick_cmd());
        6: cyc(1'($urandom), 1'($urandom), rand_addr($urandom_range(0, 2)), pick_cmd(), 1'b1);
        7: cyc(1'b1, 1'b1, rand_addr($urandom_range(0, 2)), pick_cmd(), 1'b0);
        8: idle($urandom_range(1, 8));
        default: begin
          wr(rand_addr(1), 8'hAA);
          if ($urandom_range(0, 5) == 0) idle($urandom_range(TIMEOUT - 3, TIMEOUT + 2));
          else wr(rand_addr(2), 8'h55);
        end
      endcase
    end

    idle(2);
    chk("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
